// File: rtl/line_buffer_param.sv
// Parametrised row buffer: DEPTH full-width row stages that shift/load
// according to buffer_mode, with fill tracking and a window-valid flag.

// One row stage: clear has priority over load, otherwise hold.
module line_buffer_stage #(
  parameter int ROW_W = 5120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [ROW_W-1:0] d,
  output logic [ROW_W-1:0] q
);

  // row register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end

endmodule

module line_buffer_param #(
  parameter int ROW_W      = 5120,
  parameter int NUM_BLUR   = 4,
  parameter int GAUSS_TAPS = 6,
  parameter int MATCH_TAPS = 3,
  parameter int CNT_W      = 4,
  localparam int DEPTH     = 2 + 2*NUM_BLUR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                buffer_mode,
  input  logic                      buffer_we,
  input  logic                      fill_zero,
  input  logic                      fill_rep,
  input  logic                      flush,
  input  logic [ROW_W-1:0]          in_data,
  input  logic [ROW_W-1:0]          img_data,
  input  logic [NUM_BLUR*ROW_W-1:0] blur_data,
  output logic [DEPTH*ROW_W-1:0]    buffer_data,
  output logic [CNT_W-1:0]          fill_cnt,
  output logic                      window_valid
);

  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_GAUSS  = 3'd1,
    M_DETECT = 3'd2,
    M_MATCH  = 3'd3
  } mode_t;

  localparam logic [CNT_W-1:0] G_THR = CNT_W'(GAUSS_TAPS);
  localparam logic [CNT_W-1:0] D_THR = CNT_W'(2);
  localparam logic [CNT_W-1:0] M_THR = CNT_W'(MATCH_TAPS);

  logic [DEPTH-1:0][ROW_W-1:0] stg;
  logic [2:0]                  prev_mode;
  logic                        idle, rsvd, clr, push, chg;

  assign idle = (buffer_mode == M_IDLE);
  assign rsvd = buffer_mode[2];
  // IDLE and flush both wipe the bank; IDLE wins but the effect is identical
  assign clr  = idle | flush;
  assign push = buffer_we & ~clr & ~rsvd;
  assign chg  = (buffer_mode != prev_mode);

  assign buffer_data = stg;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stg
    logic [ROW_W-1:0] d;

    if (s == 0) begin : g_head
      // stage 0 source: new row, zero row or replicate of itself
      always_comb begin
        d = stg[0];
        case (buffer_mode)
          M_GAUSS:  d = fill_zero ? '0 : (fill_rep ? stg[0] : img_data);
          M_DETECT: d = img_data;
          M_MATCH:  d = in_data;
          default:  d = stg[0];
        endcase
      end
    end else begin : g_body
      localparam bit G_SH = (s < GAUSS_TAPS);
      localparam bit M_SH = (s < MATCH_TAPS);
      logic [ROW_W-1:0] det_src;

      // DETECT pairs: even stages take a blur row, odd stages delay it by one push
      if ((s % 2) == 0) begin : g_blur
        assign det_src = blur_data[((s-2)/2)*ROW_W +: ROW_W];
      end else begin : g_pair
        assign det_src = stg[s-1];
      end

      // shift from the previous stage inside the active chain, hold past it
      always_comb begin
        d = stg[s];
        case (buffer_mode)
          M_GAUSS:  if (G_SH) d = stg[s-1];
          M_DETECT: d = det_src;
          M_MATCH:  if (M_SH) d = stg[s-1];
          default:  d = stg[s];
        endcase
      end
    end

    line_buffer_stage #(.ROW_W(ROW_W)) u_stg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .ld    (push),
      .d     (d),
      .q     (stg[s])
    );
  end

  // mode history for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_mode <= M_IDLE;
    else        prev_mode <= buffer_mode;
  end

  // saturating fill counter; a mode change restarts the count at this push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     fill_cnt <= '0;
    else if (clr)                   fill_cnt <= '0;
    else if (rsvd)                  fill_cnt <= fill_cnt;
    else if (chg)                   fill_cnt <= push ? CNT_W'(1) : '0;
    else if (push && ~&fill_cnt)    fill_cnt <= fill_cnt + 1'b1;
  end

  // window depth threshold per mode
  always_comb begin
    window_valid = 1'b0;
    case (buffer_mode)
      M_GAUSS:  window_valid = (fill_cnt >= G_THR);
      M_DETECT: window_valid = (fill_cnt >= D_THR);
      M_MATCH:  window_valid = (fill_cnt >= M_THR);
      default:  window_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_line_buffer_param.sv
// Directed bench for line_buffer_param at ROW_W=8, NUM_BLUR=4 (10 stages).
module tb_line_buffer_param;

  localparam int ROW_W = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 2 + 2*NB;

  logic                  clk, rst_n;
  logic [2:0]            buffer_mode;
  logic                  buffer_we, fill_zero, fill_rep, flush;
  logic [ROW_W-1:0]      in_data, img_data;
  logic [NB*ROW_W-1:0]   blur_data;
  logic [DEPTH*ROW_W-1:0] buffer_data;
  logic [3:0]            fill_cnt;
  logic                  window_valid;

  int n_chk = 0;
  int n_err = 0;

  line_buffer_param #(
    .ROW_W(ROW_W), .NUM_BLUR(NB), .GAUSS_TAPS(6), .MATCH_TAPS(3), .CNT_W(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buffer_mode  (buffer_mode),
    .buffer_we    (buffer_we),
    .fill_zero    (fill_zero),
    .fill_rep     (fill_rep),
    .flush        (flush),
    .in_data      (in_data),
    .img_data     (img_data),
    .blur_data    (blur_data),
    .buffer_data  (buffer_data),
    .fill_cnt     (fill_cnt),
    .window_valid (window_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // one clock edge, then sample 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] m, input logic we, input logic fz, input logic fr,
                      input logic [7:0] img, input logic [7:0] ind, input logic [31:0] blur);
    buffer_mode = m; buffer_we = we; fill_zero = fz; fill_rep = fr;
    img_data = img; in_data = ind; blur_data = blur;
    step();
    buffer_we = 1'b0; fill_zero = 1'b0; fill_rep = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; buffer_mode = 3'd0; buffer_we = 1'b0; fill_zero = 1'b0;
    fill_rep = 1'b0; flush = 1'b0; in_data = '0; img_data = '0; blur_data = '0;
    #2;
    chk("rst_data", 80'(buffer_data), 80'h0);
    chk("rst_cnt",  80'(fill_cnt), 80'd0);
    chk("rst_wv",   80'(window_valid), 80'd0);
    #10 rst_n = 1'b1;

    // 1: GAUSSIAN fill 0x11..0x66
    for (int i = 1; i <= 6; i++) begin
      push(3'd1, 1'b1, 1'b0, 1'b0, 8'(8'h11 * i), 8'h0, 32'h0);
      if (i == 5) begin
        chk("g_cnt5", 80'(fill_cnt), 80'd5);
        chk("g_wv5",  80'(window_valid), 80'd0);
      end
    end
    chk("g_data", 80'(buffer_data), 80'h00000000112233445566);
    chk("g_cnt6", 80'(fill_cnt), 80'd6);
    chk("g_wv6",  80'(window_valid), 80'd1);

    // 2: replicate / zero pushes
    push(3'd1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h0, 32'h0);
    push(3'd1, 1'b1, 1'b0, 1'b1, 8'hEE, 8'h0, 32'h0);
    push(3'd1, 1'b1, 1'b0, 1'b1, 8'hEE, 8'h0, 32'h0);
    push(3'd1, 1'b1, 1'b1, 1'b1, 8'hEE, 8'h0, 32'h0);
    chk("rep_data", 80'(buffer_data), 80'h000000005566A5A5A500);
    push(3'd1, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h0, 32'h0);
    push(3'd1, 1'b0, 1'b1, 1'b0, 8'hEE, 8'h0, 32'h0);
    chk("nowe_data", 80'(buffer_data), 80'h000000005566A5A5A500);
    chk("rep_cnt", 80'(fill_cnt), 80'd10);

    // 3: DETECT two pushes
    push(3'd2, 1'b1, 1'b0, 1'b0, 8'h01, 8'h0, 32'h40302010);
    chk("d_cnt1", 80'(fill_cnt), 80'd1);
    chk("d_wv1",  80'(window_valid), 80'd0);
    push(3'd2, 1'b1, 1'b1, 1'b1, 8'h02, 8'h0, 32'h41312111);
    chk("d_data", 80'(buffer_data), 80'h40413031202110110102);
    chk("d_wv2",  80'(window_valid), 80'd1);

    // 4: GAUSSIAN refill, then MATCH x5
    for (int i = 1; i <= 6; i++) push(3'd1, 1'b1, 1'b0, 1'b0, 8'(8'h11 * i), 8'h0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      push(3'd3, 1'b1, 1'b0, 1'b0, 8'h0, 8'(8'hC0 + i), 32'h0);
      if (i == 2) chk("m_wv2", 80'(window_valid), 80'd0);
      if (i == 3) chk("m_wv3", 80'(window_valid), 80'd1);
    end
    chk("m_data", 80'(buffer_data), 80'h40413031112233C3C4C5);
    chk("m_cnt",  80'(fill_cnt), 80'd5);

    // 5: saturation, flush, restart
    for (int i = 0; i < 15; i++) push(3'd3, 1'b1, 1'b0, 1'b0, 8'h0, 8'(i), 32'h0);
    chk("sat_cnt", 80'(fill_cnt), 80'd15);
    flush = 1'b1;
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'h0, 8'hFF, 32'h0);
    flush = 1'b0;
    chk("fl_data", 80'(buffer_data), 80'h0);
    chk("fl_cnt",  80'(fill_cnt), 80'd0);
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'h0, 8'h5A, 32'h0);
    chk("fl_push_cnt",  80'(fill_cnt), 80'd1);
    chk("fl_push_data", 80'(buffer_data), 80'h5A);

    // 6: async reset mid-burst, then reserved-mode hold
    buffer_mode = 3'd3; buffer_we = 1'b1; in_data = 8'h61;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 80'(buffer_data), 80'h0);
    chk("arst_cnt",  80'(fill_cnt), 80'd0);
    #1 rst_n = 1'b1;
    buffer_we = 1'b0;
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'h0, 8'h77, 32'h0);
    chk("post_rst_data", 80'(buffer_data), 80'h77);
    push(3'd5, 1'b1, 1'b1, 1'b0, 8'h99, 8'h88, 32'hFFFFFFFF);
    chk("rsv_data", 80'(buffer_data), 80'h77);
    chk("rsv_cnt",  80'(fill_cnt), 80'd1);
    chk("rsv_wv",   80'(window_valid), 80'd0);
    push(3'd0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h33, 32'h0);
    chk("idle_data", 80'(buffer_data), 80'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/line_buffer_param.md
Name: line_buffer_param

Overview:
- Parametrised successor to the fixed 10-row line buffer.
- Holds DEPTH full-width image rows as a shift/load register bank that feeds the Gaussian, DoG-detect and match datapaths.
- Row width, blur-tap count and per-mode window depth are generic.
- Adds fill tracking, a window-valid flag, replicate-border padding, synchronous flush and mode-change detection.

Parameters:
ROW_W, 5120, bits per row (pixels x pixel width)
NUM_BLUR, 4, number of blur_data inputs used in DETECT mode
DEPTH, 2+2*NUM_BLUR, number of row stages (fixed by NUM_BLUR; not overridable independently)
GAUSS_TAPS, 6, stages forming the shift chain in GAUSSIAN mode (1..DEPTH)
MATCH_TAPS, 3, stages forming the shift chain in MATCH mode (1..DEPTH)
CNT_W, 4, width of fill counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
buffer_mode  in  3  0 IDLE, 1 GAUSSIAN, 2 DETECT, 3 MATCH, 4-7 reserved
buffer_we  in  1  push strobe, one row per cycle
fill_zero  in  1  with buffer_we in GAUSSIAN: push all-zero row
fill_rep  in  1  with buffer_we in GAUSSIAN: push copy of stage 0 (border replicate)
flush  in  1  synchronous clear of all stages and counter
in_data  in  ROW_W  row source for MATCH
img_data  in  ROW_W  row source for GAUSSIAN/DETECT
blur_data  in  NUM_BLUR*ROW_W  blur row k at bits [k*ROW_W +: ROW_W]
buffer_data  out  DEPTH*ROW_W  stage s at bits [s*ROW_W +: ROW_W]
fill_cnt  out  CNT_W  rows pushed since last clear/mode change, saturating
window_valid  out  1  fill_cnt >= window depth of current mode

Behaviour:
- Reset (async, rst_n=0): all stages 0, fill_cnt 0, prev_mode register 0 (IDLE). window_valid is then 0.
- Priority per cycle: reset > IDLE > flush > reserved mode (hold) > push.
- IDLE: all stages <= 0, fill_cnt <= 0, regardless of buffer_we/flush.
- flush=1 (non-IDLE): all stages <= 0, fill_cnt <= 0; buffer_we ignored that cycle.
- Push occurs only when buffer_we=1; stages hold otherwise.
  - fill_zero/fill_rep without buffer_we have no effect (intentional change from the fixed buffer).
- GAUSSIAN push:
  - stage0 <= 0 if fill_zero; else stage0 (unchanged) if fill_rep; else img_data.
  - fill_zero wins over fill_rep.
  - stage s <= stage s-1 for 1 <= s < GAUSS_TAPS; stages >= GAUSS_TAPS hold.
- DETECT push:
  - stage0 <= img_data; stage1 <= stage0.
  - For k in 0..NUM_BLUR-1: stage 2+2k <= blur_k, stage 3+2k <= stage 2+2k.
  - fill_zero/fill_rep ignored.
- MATCH push:
  - stage0 <= in_data; stage s <= stage s-1 for s < MATCH_TAPS; others hold.
- Reserved modes 4-7: stages and fill_cnt hold; window_valid 0.
- Mode change (buffer_mode != prev_mode, both non-IDLE):
  - Stage contents are NOT cleared.
  - fill_cnt <= (push this cycle ? 1 : 0).
  - prev_mode <= buffer_mode every cycle.
- fill_cnt:
  - +1 per push (including zero/replicate pushes).
  - Saturates at 2^CNT_W-1, no wrap.
- window_valid: combinational from registered fill_cnt and current buffer_mode. Thresholds: GAUSSIAN GAUSS_TAPS, DETECT 2, MATCH MATCH_TAPS, IDLE/reserved never.
- Latency: a pushed row is visible on stage0 of buffer_data the cycle after the push edge; stage n of a shift chain sees it n cycles later.
- Reset deasserted mid-operation: the next edge behaves as from IDLE; no partial rows remain.

Test Plan (ROW_W=8, NUM_BLUR=4, GAUSS_TAPS=6, MATCH_TAPS=3):
1. Reset then GAUSSIAN with img_data=0x11,0x22,...,0x66 over 6 pushes -> stages0..5 = 0x66..0x11; fill_cnt 6; window_valid rises the cycle after the 6th push; stages 6-9 stay 0.
2. GAUSSIAN: push 0xA5, then fill_rep+we twice, then fill_zero+fill_rep+we -> stage0..3 = 0x00,0xA5,0xA5,0xA5; fill_rep/fill_zero with we=0 leave all stages unchanged.
3. DETECT push with img=0x01, blur=0x40,0x30,0x20,0x10 (k=3..0), then second push img=0x02, blur=0x41,0x31,0x21,0x11 -> stages0..9 = 02,01,11,10,21,20,31,30,41,40; window_valid=1 after 2 pushes.
4. MATCH: 5 pushes of in_data 0xC1..0xC5 after GAUSSIAN fill -> stages0..2 = C5,C4,C3; stages3..5 retain GAUSSIAN data; fill_cnt 5, counter reset on mode change then counted the pushes.
5. 20 pushes in MATCH -> fill_cnt holds 15; assert flush with we=1 -> all stages 0, fill_cnt 0; next push -> fill_cnt 1.
6. Assert rst_n low asynchronously between edges mid-push burst -> outputs 0 immediately; buffer_mode=5 with we=1 -> no change, window_valid 0.
